// File: rtl/svnet_ram_arbiter_if.sv
// svnet_ram_arbiter_if
//   Client-side bus of the shared-RAM arbiter. All per-client signals are
//   packed arrays indexed by client number.
//   req_write / req_write_address / req_write_data : write requests
//   req_write_ready                                : one-hot write accept
//   req_read / req_read_address                    : read requests
//   req_read_ready                                 : one-hot read accept
//   resp_read_data_valid                           : one-hot read-return strobe
//   resp_read_data                                 : read-return data (shared)
//   master modport: the clients; slave modport: the arbiter.
interface svnet_ram_arbiter_if #(
  parameter int REQUESTERS = 4,
  parameter int DEPTH      = 256,
  parameter int WIDTH      = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [REQUESTERS-1:0]            req_write;
  logic [REQUESTERS-1:0][AW-1:0]    req_write_address;
  logic [REQUESTERS-1:0][WIDTH-1:0] req_write_data;
  logic [REQUESTERS-1:0]            req_write_ready;
  logic [REQUESTERS-1:0]            req_read;
  logic [REQUESTERS-1:0][AW-1:0]    req_read_address;
  logic [REQUESTERS-1:0]            req_read_ready;
  logic [REQUESTERS-1:0]            resp_read_data_valid;
  logic [WIDTH-1:0]                 resp_read_data;

  modport master (
    output req_write, req_write_address, req_write_data,
    output req_read, req_read_address,
    input  req_write_ready, req_read_ready,
    input  resp_read_data_valid, resp_read_data
  );

  modport slave (
    input  req_write, req_write_address, req_write_data,
    input  req_read, req_read_address,
    output req_write_ready, req_read_ready,
    output resp_read_data_valid, resp_read_data
  );
endinterface

// File: rtl/svnet_ram_arbiter.sv
// svnet_ram_arbiter
//   Shares one svnet_ram between REQUESTERS clients. Write and read ports
//   each have an independent round-robin arbiter that issues at most once
//   every 2 cycles. A read that would issue in the same cycle as a write to
//   the same address is held back one cycle so it sees the new data. Each
//   issued read is tagged with its client index; returns are routed back
//   through a one-hot strobe.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   bus (slave)          : client request / response bus
//   ram_write, ram_write_address, ram_write_data : registered RAM write drive
//   ram_read, ram_read_address                   : registered RAM read drive
//   ram_read_data_valid, ram_read_data           : RAM read return
//   error                : sticky; return with no outstanding tag, or tag overflow
module svnet_ram_arbiter #(
  parameter int  REQUESTERS = 4,
  parameter int  DEPTH      = 256,
  parameter int  WIDTH      = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  svnet_ram_arbiter_if.slave bus,
  output logic              ram_write,
  output logic [AW-1:0]     ram_write_address,
  output logic [WIDTH-1:0]  ram_write_data,
  output logic              ram_read,
  output logic [AW-1:0]     ram_read_address,
  input  logic              ram_read_data_valid,
  input  logic [WIDTH-1:0]  ram_read_data,
  output logic              error
);
  localparam int IW = $clog2(REQUESTERS);

  typedef enum logic {ST_IDLE, ST_COOL} arb_state_t;

  arb_state_t      w_state_reg, w_state_next;
  arb_state_t      r_state_reg, r_state_next;
  logic [IW-1:0]   w_ptr_reg, w_ptr_next;
  logic [IW-1:0]   r_ptr_reg, r_ptr_next;

  logic [IW-1:0]   w_sel, r_sel;
  logic            w_hit, r_hit;
  logic            w_go, r_want, r_go, hazard;

  // First requesting client at or after ptr, wrapping modulo REQUESTERS.
  function automatic logic [IW-1:0] rr_pick(
    input  logic [REQUESTERS-1:0] req,
    input  logic [IW-1:0]         ptr,
    output logic                  hit
  );
    logic [IW-1:0] sel;
    logic [IW-1:0] idx;
    int unsigned   sum;
    sel = '0;
    hit = 1'b0;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      sum = (32'(ptr) + k) % REQUESTERS;
      idx = IW'(sum);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
    return sel;
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] sel);
    return (sel == IW'(REQUESTERS - 1)) ? '0 : sel + 1'b1;
  endfunction

  // Grant decision. Ready is forced low while reset is asserted so clients
  // never see an accept that the registers would throw away.
  always_comb begin
    w_hit  = 1'b0;
    r_hit  = 1'b0;
    w_sel  = rr_pick(bus.req_write, w_ptr_reg, w_hit);
    r_sel  = rr_pick(bus.req_read, r_ptr_reg, r_hit);
    w_go   = rst_n && (w_state_reg == ST_IDLE) && w_hit;
    r_want = rst_n && (r_state_reg == ST_IDLE) && r_hit;
    // Same-cycle read of the address being written: let the write go first,
    // the read retries next cycle with its pointer and state untouched.
    hazard = w_go && r_want &&
             (bus.req_write_address[w_sel] == bus.req_read_address[r_sel]);
    r_go   = r_want && !hazard;
  end

  for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_ready
    assign bus.req_write_ready[gi] = w_go && (w_sel == IW'(gi));
    assign bus.req_read_ready[gi]  = r_go && (r_sel == IW'(gi));
  end

  // Arbiter FSMs: a grant always costs one cooldown cycle.
  always_comb begin
    w_state_next = w_state_reg;
    w_ptr_next   = w_ptr_reg;
    r_state_next = r_state_reg;
    r_ptr_next   = r_ptr_reg;
    case (w_state_reg)
      ST_IDLE: if (w_go) begin
        w_state_next = ST_COOL;
        w_ptr_next   = rr_next(w_sel);
      end
      ST_COOL: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    case (r_state_reg)
      ST_IDLE: if (r_go) begin
        r_state_next = ST_COOL;
        r_ptr_next   = rr_next(r_sel);
      end
      ST_COOL: r_state_next = ST_IDLE;
      default: r_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg <= ST_IDLE;
      r_state_reg <= ST_IDLE;
      w_ptr_reg   <= '0;
      r_ptr_reg   <= '0;
    end else begin
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
      w_ptr_reg   <= w_ptr_next;
      r_ptr_reg   <= r_ptr_next;
    end
  end

  // Registered RAM drive; everything returns to 0 on cycles without a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_write         <= 1'b0;
      ram_write_address <= '0;
      ram_write_data    <= '0;
      ram_read          <= 1'b0;
      ram_read_address  <= '0;
    end else begin
      ram_write         <= w_go;
      ram_write_address <= w_go ? bus.req_write_address[w_sel] : '0;
      ram_write_data    <= w_go ? bus.req_write_data[w_sel] : '0;
      ram_read          <= r_go;
      ram_read_address  <= r_go ? bus.req_read_address[r_sel] : '0;
    end
  end

  // Read tag FIFO. Two entries cover the 3-cycle return latency at one read
  // every 2 cycles.
  logic [IW-1:0] tag_mem_reg [2];
  logic          tag_wr_reg, tag_rd_reg;
  logic [1:0]    tag_count_reg;
  logic          tag_push, tag_pop, tag_full, tag_empty, tag_overflow;
  logic [IW-1:0] tag_head;

  assign tag_full     = (tag_count_reg == 2'd2);
  assign tag_empty    = (tag_count_reg == 2'd0);
  assign tag_pop      = ram_read_data_valid && !tag_empty;
  assign tag_overflow = r_go && tag_full && !tag_pop;
  assign tag_push     = r_go && !tag_overflow;
  assign tag_head     = tag_mem_reg[tag_rd_reg];

  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_mem_reg[tag_wr_reg] <= r_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr_reg    <= 1'b0;
      tag_rd_reg    <= 1'b0;
      tag_count_reg <= 2'd0;
      error         <= 1'b0;
    end else begin
      if (tag_push) tag_wr_reg <= ~tag_wr_reg;
      if (tag_pop)  tag_rd_reg <= ~tag_rd_reg;
      case ({tag_push, tag_pop})
        2'b10:   tag_count_reg <= tag_count_reg + 2'd1;
        2'b01:   tag_count_reg <= tag_count_reg - 2'd1;
        default: tag_count_reg <= tag_count_reg;
      endcase
      // A return with nothing outstanding (e.g. issued before a reset) is dropped.
      if ((ram_read_data_valid && tag_empty) || tag_overflow) begin
        error <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_resp
    assign bus.resp_read_data_valid[gi] = tag_pop && (tag_head == IW'(gi));
  end

  assign bus.resp_read_data = ram_read_data;

endmodule
